// File: rtl/trivium_init_ctrl.sv
// Trivium init controller: byte-serial key/IV capture, 1-cycle register load, warm-up, then gated keystream.
// Optional ks_cnt_o keystream counter enabled by `define TRIVIUM_INIT_CTRL_KS_CNT_EN.
module trivium_init_ctrl #(
    parameter int WARMUP_CYCLES = 1152,
    parameter int CNT_W         = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   dat_i,
    input  logic         vld_i,
    output logic         rdy_o,
    input  logic         rekey_i,
    output logic         ld_o,
    output logic [92:0]  ld_a_o,
    output logic [83:0]  ld_b_o,
    output logic [110:0] ld_c_o,
    output logic         ce_o,
    input  logic         z_i,
    input  logic         ks_req_i,
    output logic         ks_o,
    output logic         ks_vld_o,
    output logic         busy_o
`ifdef TRIVIUM_INIT_CTRL_KS_CNT_EN
    ,
    output logic [31:0]  ks_cnt_o
`endif
);

    typedef enum logic [2:0] {S_KEY, S_IV, S_LOAD, S_WARM, S_RUN} state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [79:0]      key_q, key_d;
    logic [79:0]      iv_q, iv_d;
    logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
    logic             ks_q, ks_d;
    logic             ks_vld_q, ks_vld_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        key_d      = key_q;
        iv_d       = iv_q;
        warm_cnt_d = warm_cnt_q;
        ks_d       = ks_q;
        ks_vld_d   = 1'b0;
        rdy_o      = 1'b0;
        ld_o       = 1'b0;
        ce_o       = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            S_KEY: begin
                rdy_o = 1'b1;
                if (vld_i) begin
                    key_d[{byte_cnt_q, 3'b000} +: 8] = dat_i;
                    if (byte_cnt_q == 4'd9) begin
                        byte_cnt_d = 4'd0;
                        state_d    = S_IV;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            S_IV: begin
                rdy_o = 1'b1;
                if (vld_i) begin
                    iv_d[{byte_cnt_q, 3'b000} +: 8] = dat_i;
                    if (byte_cnt_q == 4'd9) begin
                        byte_cnt_d = 4'd0;
                        state_d    = S_LOAD;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            S_LOAD: begin
                ld_o       = 1'b1;
                busy_o     = 1'b1;
                warm_cnt_d = '0;
                state_d    = S_WARM;
            end
            S_WARM: begin
                ce_o       = 1'b1;
                busy_o     = 1'b1;
                warm_cnt_d = warm_cnt_q + 1'b1;
                if (warm_cnt_q == WARM_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // rekey wins over a same-cycle keystream request
                if (rekey_i) begin
                    state_d    = S_KEY;
                    byte_cnt_d = 4'd0;
                end else if (ks_req_i) begin
                    ce_o     = 1'b1;
                    ks_d     = z_i;
                    ks_vld_d = 1'b1;
                end
            end
            default: state_d = S_KEY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_KEY;
            byte_cnt_q <= 4'd0;
            key_q      <= '0;
            iv_q       <= '0;
            warm_cnt_q <= '0;
            ks_q       <= 1'b0;
            ks_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            key_q      <= key_d;
            iv_q       <= iv_d;
            warm_cnt_q <= warm_cnt_d;
            ks_q       <= ks_d;
            ks_vld_q   <= ks_vld_d;
        end
    end

    assign ld_a_o   = {13'b0, key_q};
    assign ld_b_o   = {4'b0, iv_q};
    assign ld_c_o   = {3'b111, 108'b0};
    assign ks_o     = ks_q;
    assign ks_vld_o = ks_vld_q;

`ifdef TRIVIUM_INIT_CTRL_KS_CNT_EN
    logic [31:0] ks_cnt_q, ks_cnt_d;

    always_comb begin
        ks_cnt_d = ks_cnt_q;
        if (ld_o)                              ks_cnt_d = '0;
        else if (ks_vld_d && ks_cnt_q != '1)   ks_cnt_d = ks_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ks_cnt_q <= '0;
        else       ks_cnt_q <= ks_cnt_d;
    end

    assign ks_cnt_o = ks_cnt_q;
`endif

endmodule
